// File: rtl/generic_fifo_flagged.sv
// Synchronous FIFO with status flags, sticky error flags and an optional
// first-word-fall-through read port. Storage is an inferred memory array.
module generic_fifo_flagged #(
  parameter int GENERIC_FIFO_DEPTH        = 8,
  parameter int GENERIC_FIFO_DATA_WIDTH   = 32,
  parameter int GENERIC_FIFO_AF_THRESHOLD = 2,
  parameter int GENERIC_FIFO_AE_THRESHOLD = 2,
  parameter int GENERIC_FIFO_FWFT         = 0,
  localparam int GENERIC_FIFO_ADDR_WIDTH  = $clog2(GENERIC_FIFO_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 reset_poweron,
  input  logic                                 clear,
  input  logic                                 write,
  input  logic [GENERIC_FIFO_DATA_WIDTH-1:0]   write_data,
  input  logic                                 read,
  output logic [GENERIC_FIFO_DATA_WIDTH-1:0]   read_data,
  output logic                                 read_valid,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  output logic [GENERIC_FIFO_ADDR_WIDTH:0]     depth,
  output logic                                 overflow,
  output logic                                 underflow
);

  localparam int AW = GENERIC_FIFO_ADDR_WIDTH;
  localparam int DW = GENERIC_FIFO_DATA_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(GENERIC_FIFO_DEPTH);
  localparam logic [AW:0] AF_LEVEL = (AW+1)'(GENERIC_FIFO_DEPTH - GENERIC_FIFO_AF_THRESHOLD);
  localparam logic [AW:0] AE_LEVEL = (AW+1)'(GENERIC_FIFO_AE_THRESHOLD);

  logic [DW-1:0] mem [GENERIC_FIFO_DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   depth_q, depth_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          read_acc;
  logic          write_acc;
  logic          flush;

  // Status flags come straight from the registered occupancy.
  assign empty        = (depth_q == '0);
  assign full         = (depth_q == FULL_CNT);
  assign almost_full  = (depth_q >= AF_LEVEL);
  assign almost_empty = (depth_q <= AE_LEVEL);
  assign depth        = depth_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Reset or clear swallows any request made in the same cycle.
  assign flush     = reset_poweron | clear;
  assign read_acc  = read & ~empty & ~flush;
  assign write_acc = write & (~full | read_acc) & ~flush;

  // Next-state for pointers, occupancy and sticky errors.
  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wp_d        = '0;
      rp_d        = '0;
      depth_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (write_acc) wp_d = wp_q + 1'b1;
      if (read_acc)  rp_d = rp_q + 1'b1;
      if (write_acc && !read_acc)      depth_d = depth_q + 1'b1;
      else if (read_acc && !write_acc) depth_d = depth_q - 1'b1;
      if (write && !write_acc) overflow_d  = 1'b1;
      if (read && !read_acc)   underflow_d = 1'b1;
    end
  end

  // Control state register with synchronous power-on reset.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wp_q        <= '0;
      rp_q        <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (write_acc) mem[wp_q] <= write_data;
  end

  generate
    if (GENERIC_FIFO_FWFT == 0) begin : g_std
      logic [DW-1:0] read_data_q;
      logic          read_valid_q;

      // Registered read port: data lands the cycle after an accepted pop.
      always_ff @(posedge clk) begin
        if (flush) begin
          read_data_q  <= '0;
          read_valid_q <= 1'b0;
        end else begin
          read_valid_q <= read_acc;
          if (read_acc) read_data_q <= mem[rp_q];
        end
      end

      assign read_data  = read_data_q;
      assign read_valid = read_valid_q;
    end else begin : g_fwft
      // Head entry is always presented while the FIFO holds data.
      assign read_data  = empty ? '0 : mem[rp_q];
      assign read_valid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_generic_fifo_flagged.sv
// Directed bench for generic_fifo_flagged: one standard-mode and one
// first-word-fall-through instance, checked with immediate assertions.
module tb_generic_fifo_flagged;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c0 = 1'b0, w0 = 1'b0, r0 = 1'b0;
  logic [31:0] d0 = '0;
  logic        c1 = 1'b0, w1 = 1'b0, r1 = 1'b0;
  logic [31:0] d1 = '0;

  logic [31:0] rd0, rd1;
  logic        rv0, em0, fu0, af0, ae0, ov0, un0;
  logic        rv1, em1, fu1, af1, ae1, ov1, un1;
  logic [3:0]  dp0, dp1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generic_fifo_flagged #(.GENERIC_FIFO_FWFT(0)) u_std (
    .clk(clk), .reset_poweron(rst), .clear(c0), .write(w0), .write_data(d0),
    .read(r0), .read_data(rd0), .read_valid(rv0), .empty(em0), .full(fu0),
    .almost_full(af0), .almost_empty(ae0), .depth(dp0), .overflow(ov0),
    .underflow(un0));

  generic_fifo_flagged #(.GENERIC_FIFO_FWFT(1)) u_fwft (
    .clk(clk), .reset_poweron(rst), .clear(c1), .write(w1), .write_data(d1),
    .read(r1), .read_data(rd1), .read_valid(rv1), .empty(em1), .full(fu1),
    .almost_full(af1), .almost_empty(ae1), .depth(dp1), .overflow(ov1),
    .underflow(un1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_empty", 32'(em0), 32'(1));
    chk("rst_full", 32'(fu0), 32'(0));
    chk("rst_depth", 32'(dp0), 32'(0));
    chk("rst_ae", 32'(ae0), 32'(1));
    chk("rst_af", 32'(af0), 32'(0));
    chk("rst_ovf", 32'(ov0), 32'(0));
    chk("rst_udf", 32'(un0), 32'(0));
    chk("rst_rvalid", 32'(rv0), 32'(0));
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_fwft_rvalid", 32'(rv1), 32'(0));

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      w0 = 1'b1; d0 = 32'(i * 32'h11);
      tick();
      chk("fill_depth", 32'(dp0), 32'(i));
      chk("fill_af", 32'(af0), 32'(i >= 6));
      chk("fill_full", 32'(fu0), 32'(i == 8));
      chk("fill_ae", 32'(ae0), 32'(i <= 2));
    end

    // Write into full FIFO is dropped
    d0 = 32'h99;
    tick();
    chk("ovf_flag", 32'(ov0), 32'(1));
    chk("ovf_depth", 32'(dp0), 32'(8));

    // Simultaneous write+read on full: both accepted
    d0 = 32'hAA; r0 = 1'b1;
    tick();
    w0 = 1'b0;
    chk("fullwr_depth", 32'(dp0), 32'(8));
    chk("fullwr_rdata", rd0, 32'h11);
    chk("fullwr_rvalid", 32'(rv0), 32'(1));

    // Drain: 0x22..0x88 then 0xAA; 0x99 must never appear
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("drain_rdata", rd0, (i == 9) ? 32'hAA : 32'(i * 32'h11));
      chk("drain_rvalid", 32'(rv0), 32'(1));
      chk("drain_depth", 32'(dp0), 32'(9 - i));
    end
    r0 = 1'b0;
    tick();
    chk("idle_rvalid", 32'(rv0), 32'(0));
    chk("idle_rdata_hold", rd0, 32'hAA);
    chk("idle_empty", 32'(em0), 32'(1));

    // Read on empty sets underflow
    r0 = 1'b1;
    tick();
    chk("udf_flag", 32'(un0), 32'(1));
    chk("udf_depth", 32'(dp0), 32'(0));
    chk("udf_rvalid", 32'(rv0), 32'(0));
    // Write+read on empty: write only
    w0 = 1'b1; d0 = 32'h5A;
    tick();
    w0 = 1'b0;
    chk("emptywr_depth", 32'(dp0), 32'(1));
    chk("emptywr_udf", 32'(un0), 32'(1));
    chk("emptywr_rvalid", 32'(rv0), 32'(0));
    tick();
    r0 = 1'b0;
    chk("emptywr_rdata", rd0, 32'h5A);
    chk("emptywr_depth2", 32'(dp0), 32'(0));

    // Clear at depth 5 with overflow still set and a write pending
    for (int i = 0; i < 5; i++) begin
      w0 = 1'b1; d0 = 32'(32'h30 + i);
      tick();
    end
    chk("pre_clr_depth", 32'(dp0), 32'(5));
    chk("pre_clr_ovf", 32'(ov0), 32'(1));
    c0 = 1'b1; d0 = 32'hEE;
    tick();
    c0 = 1'b0; w0 = 1'b0;
    chk("clr_depth", 32'(dp0), 32'(0));
    chk("clr_empty", 32'(em0), 32'(1));
    chk("clr_ovf", 32'(ov0), 32'(0));
    chk("clr_udf", 32'(un0), 32'(0));
    chk("clr_rdata", rd0, 32'h0);
    tick();
    chk("clr_write_dropped", 32'(dp0), 32'(0));

    // Wrap-around at depth 3
    for (int i = 0; i < 3; i++) begin
      w0 = 1'b1; d0 = 32'(32'h100 + i);
      tick();
    end
    w0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      w0 = 1'b1; r0 = 1'b1; d0 = 32'(32'h103 + i);
      tick();
      chk("wrap_rdata", rd0, 32'(32'h100 + i));
      chk("wrap_depth", 32'(dp0), 32'(3));
    end
    w0 = 1'b0;
    for (int i = 20; i < 23; i++) begin
      tick();
      chk("wrap_tail", rd0, 32'(32'h100 + i));
    end
    r0 = 1'b0;
    tick();
    chk("wrap_empty", 32'(em0), 32'(1));

    // FWFT: write into empty shows data next cycle without a read
    w1 = 1'b1; d1 = 32'hA5;
    tick();
    w1 = 1'b0;
    chk("fwft_rvalid", 32'(rv1), 32'(1));
    chk("fwft_rdata", rd1, 32'hA5);
    w1 = 1'b1; d1 = 32'hB6;
    tick();
    w1 = 1'b0;
    chk("fwft_head_hold", rd1, 32'hA5);
    chk("fwft_depth2", 32'(dp1), 32'(2));
    r1 = 1'b1;
    tick();
    chk("fwft_advance", rd1, 32'hB6);
    tick();
    r1 = 1'b0;
    chk("fwft_empty", 32'(em1), 32'(1));
    chk("fwft_rvalid_low", 32'(rv1), 32'(0));

    // Reset together with requests: nothing accepted, no error flags
    w0 = 1'b1; r0 = 1'b1; d0 = 32'h77; rst = 1'b1;
    tick();
    rst = 1'b0; w0 = 1'b0; r0 = 1'b0;
    chk("rstreq_depth", 32'(dp0), 32'(0));
    chk("rstreq_ovf", 32'(ov0), 32'(0));
    chk("rstreq_udf", 32'(un0), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/generic_fifo_flagged.md
GENERIC_FIFO_FLAGGED -- requirements
Module: generic_fifo_flagged

Interface
REQ-001 SHALL have parameter GENERIC_FIFO_DEPTH, default 8, entry count; power of two, >=4.
REQ-002 SHALL have parameter GENERIC_FIFO_DATA_WIDTH, default 32, bits per entry.
REQ-003 SHALL have parameter GENERIC_FIFO_AF_THRESHOLD, default 2, free-entry count at or below which almost_full asserts; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter GENERIC_FIFO_AE_THRESHOLD, default 2, occupancy at or below which almost_empty asserts; legal range 1..DEPTH-1.
REQ-005 SHALL have parameter GENERIC_FIFO_FWFT, default 0, read mode (0 = standard, 1 = first-word-fall-through).
REQ-006 SHALL derive localparam GENERIC_FIFO_ADDR_WIDTH = $clog2(GENERIC_FIFO_DEPTH).
REQ-007 SHALL use one clock; reset is synchronous and active-high.
REQ-008 clk  input  1  rising-edge clock for all state.
REQ-009 reset_poweron  input  1  synchronous active-high reset.
REQ-010 clear  input  1  synchronous flush; no effect while reset_poweron is high.
REQ-011 write  input  1  push request.
REQ-012 write_data  input  DATA_WIDTH  push data.
REQ-013 read  input  1  pop request.
REQ-014 read_data  output  DATA_WIDTH  popped or head data.
REQ-015 read_valid  output  1  read_data qualifier.
REQ-016 empty, full, almost_full, almost_empty  output  1 each  status flags.
REQ-017 depth  output  ADDR_WIDTH+1  occupancy, 0..DEPTH inclusive.
REQ-018 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-019 Storage SHALL be a DEPTH x DATA_WIDTH array addressed by wp/rp of ADDR_WIDTH bits, wrapping DEPTH-1 -> 0.
REQ-020 A write SHALL be accepted iff write && (!full || read_accepted); an accepted write stores write_data at wp and increments wp.
REQ-021 A read SHALL be accepted iff read && !empty; an accepted read increments rp.
REQ-022 depth SHALL update next cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 When full, simultaneous write and read SHALL both be accepted; depth stays DEPTH.
REQ-024 When empty, simultaneous write and read SHALL accept the write only, reject the read, and set underflow.
REQ-025 A write rejected when full SHALL drop data, leave wp/depth unchanged, and set overflow.
REQ-026 A read rejected when empty SHALL leave rp/depth unchanged and set underflow.
REQ-027 overflow/underflow SHALL remain set until reset_poweron or clear.
REQ-028 Flags SHALL be combinational from registered depth: empty = (depth==0); full = (depth==DEPTH); almost_full = (depth >= DEPTH-AF_THRESHOLD); almost_empty = (depth <= AE_THRESHOLD).
REQ-029 Standard mode (FWFT=0): read_data SHALL be registered, loaded from mem[rp] one cycle after an accepted read, held otherwise; read_valid SHALL pulse high for exactly that cycle.
REQ-030 FWFT mode (FWFT=1): read_data SHALL equal mem[rp] combinationally whenever !empty; read_valid = !empty; an accepted read advances to the next entry in the following cycle.
REQ-031 FWFT mode: a write into an empty FIFO SHALL make read_valid high in the cycle after the write.
REQ-032 Priority SHALL be reset_poweron > clear > read/write.

Reset
REQ-033 On reset_poweron or clear, next cycle SHALL give wp=rp=0, depth=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, read_valid=0, registered read_data=0; array contents are not cleared.
REQ-034 Reset or clear asserted with write/read in the same cycle SHALL discard those requests and raise no error flags.

Verification
REQ-035 DEPTH=8, AF=2, AE=2, FWFT=0: write 0x11..0x88 over 8 cycles -> almost_full=1 when depth=6, full=1 when depth=8; then 8 reads -> read_data 0x11..0x88 in order, one cycle after each read, read_valid pulses, empty=1 at end.
REQ-036 Full FIFO, write 0x99 alone -> overflow=1, depth=8; next write+read together -> depth=8, wp and rp both advance, 0x99 never appears on read_data.
REQ-037 Empty FIFO, read alone -> underflow=1, rp unchanged; write+read together when empty -> depth=1, underflow stays 1.
REQ-038 FWFT=1: write 0xA5 into empty FIFO -> read_valid=1 and read_data=0xA5 next cycle with no read; read -> empty=1, read_valid=0 next cycle.
REQ-039 Wrap-around: 20 interleaved write/read pairs at depth 3 -> data order preserved across pointer wrap; depth stays 3.
REQ-040 Assert clear at depth=5 with overflow=1 and write=1 -> next cycle depth=0, empty=1, overflow=0, write discarded.
